// File: rtl/regfile_mp_dump_if.sv
// Dump stream between the register file and the debug/UART unit.
// The debug unit is the master (requests and accepts beats); the register file is the slave.
interface regfile_mp_dump_if #(
  parameter int WIDTH = 32,
  parameter int NB    = 5
);
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [WIDTH-1:0] dump_data;
  logic [NB-1:0]    dump_idx;
  logic             dump_busy;
  logic             dump_done;

  modport master (
    output dump_start, dump_ready,
    input  dump_valid, dump_data, dump_idx, dump_busy, dump_done
  );

  modport slave (
    input  dump_start, dump_ready,
    output dump_valid, dump_data, dump_idx, dump_busy, dump_done
  );
endinterface

// File: rtl/regfile_mp_dump.sv
// MIPS register file: NUM_RD registered read ports with write bypass, one write port, and a register dump engine.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp_dump #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NB     = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [NB-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*NB-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0]        rd_data0_comb,
  regfile_mp_dump_if.slave        dump
);

  localparam int            SLOTS    = 1 << NB;
  localparam logic [NB-1:0] LAST_IDX = NB'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  // Storage covers the full address space; slots at or above DEPTH are never written and read as zero.
  logic [WIDTH-1:0] mem [SLOTS];
  logic             addr_in_range;
  logic             write_ok;

  dump_state_t      state, state_next;
  logic             load_first, advance;
  logic [NB-1:0]    idx_q;
  logic [WIDTH-1:0] data_q;

  if (DEPTH == SLOTS) begin : g_full
    assign addr_in_range = 1'b1;
  end else begin : g_partial
    assign addr_in_range = ({1'b0, wr_addr} < (NB+1)'(DEPTH));
  end

`ifdef REGFILE_ZERO_REG_EN
  assign write_ok = enable && wr_en && addr_in_range && (wr_addr != '0);
`else
  assign write_ok = enable && wr_en && addr_in_range;
`endif

  function automatic logic [WIDTH-1:0] read_mem(input logic [NB-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0) return '0;
`endif
    return mem[a];
  endfunction

  // Read with same-edge forwarding of the write being committed.
  function automatic logic [WIDTH-1:0] fwd(input logic [NB-1:0] a);
    if (write_ok && (wr_addr == a)) return wr_data;
    return read_mem(a);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_RD; i++)
        rd_data[i*WIDTH +: WIDTH] <= fwd(rd_addr[i*NB +: NB]);
    end
  end

  // Branch-compare path: sees only committed state, never the in-flight write.
`ifdef REGFILE_ZERO_REG_EN
  assign rd_data0_comb = (rd_addr[NB-1:0] == '0) ? '0 : mem[rd_addr[NB-1:0]];
`else
  assign rd_data0_comb = mem[rd_addr[NB-1:0]];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_first = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dump.dump_start) begin
          state_next = SEND;
          load_first = 1'b1;
        end
      end
      SEND: begin
        if (dump.dump_ready) begin
          if (idx_q == LAST_IDX) state_next = DONE;
          else                   advance    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A beat is captured once and held while stalled, so later writes do not disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (load_first) begin
      idx_q  <= '0;
      data_q <= fwd('0);
    end else if (advance) begin
      idx_q  <= idx_q + NB'(1);
      data_q <= fwd(idx_q + NB'(1));
    end
  end

  assign dump.dump_valid = (state == SEND);
  assign dump.dump_busy  = (state == SEND) || (state == DONE);
  assign dump.dump_done  = (state == DONE);
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;

endmodule

// File: tb/tb_regfile_mp_dump.sv
// Self-checking bench for regfile_mp_dump: table-driven read/write vectors plus dump sequences
// scored against a reference register model.
module tb_regfile_mp_dump;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NB     = 5;
  localparam int NUM_RD = 2;
  localparam int NV     = 10;

  typedef struct {
    logic        en;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_comb;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    wr_en;
  logic [NB-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [NUM_RD*NB-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]        rd_data0_comb;

  regfile_mp_dump_if #(.WIDTH(WIDTH), .NB(NB)) dif();

  regfile_mp_dump #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NB(NB), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_data0_comb(rd_data0_comb),
    .dump(dif)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] model_mem [DEPTH];
  beat_t       beat_q [$];
  rd_exp_t     rd_q [$];
  vec_t        vecs [NV];

  function automatic logic [31:0] model_read(input logic [4:0] a);
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd0) return 32'd0;
`endif
    return model_mem[a];
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd0) return;
`endif
    model_mem[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable  = v.en;
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    rd_addr = {v.ra1, v.ra0};
  endtask

  // Full dump: expected beats come from the model at start; each accepted beat is popped and compared.
  task automatic run_dump(input bit random_ready);
    int    cycles;
    bit    prev_last;
    bit    done_seen;
    beat_t b;
    for (int i = 0; i < DEPTH; i++) begin
      b.idx  = 5'(i);
      b.data = model_read(5'(i));
      beat_q.push_back(b);
    end
    dif.dump_start = 1'b1;
    dif.dump_ready = 1'b1;
    step();
    dif.dump_start = 1'b0;
    checkOutput("dump_busy_start", 32'(dif.dump_busy), 32'd1);
    prev_last = 1'b0;
    done_seen = 1'b0;
    cycles    = 0;
    while (!done_seen && cycles < 4*DEPTH) begin
      if (dif.dump_done) begin
        checkOutput("done_after_last_beat", 32'(prev_last), 32'd1);
        done_seen = 1'b1;
      end else begin
        dif.dump_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_last = 1'b0;
        if (dif.dump_valid && dif.dump_ready) begin
          if (beat_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL dump_extra_beat: idx %0d beyond expected count", dif.dump_idx);
          end else begin
            b = beat_q.pop_front();
            checkOutput("dump_idx", 32'(dif.dump_idx), 32'(b.idx));
            checkOutput("dump_data", dif.dump_data, b.data);
            prev_last = (beat_q.size() == 0);
          end
        end
        step();
        cycles++;
      end
    end
    dif.dump_ready = 1'b0;
    if (!done_seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL dump_timeout: no dump_done within %0d cycles", 4*DEPTH);
    end
    checkOutput("dump_beats_left", 32'(beat_q.size()), 32'd0);
    beat_q.delete();
    step();
    checkOutput("done_one_cycle", 32'(dif.dump_done), 32'd0);
    checkOutput("busy_after_done", 32'(dif.dump_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cycles;
    logic [31:0] held;
    rd_exp_t     r;

    //            en    we    wa     wd             ra0    ra1    comb           exp0           exp1
    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd5,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd5,  32'h00000000, 32'h11111111, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  32'h00001234, 5'd5,  5'd5,  32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 5'd7,  32'h00000000, 5'd7,  5'd7,  32'h11111111, 32'h11111111, 32'h11111111};
    vecs[5] = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'h00000000, 32'hCAFEF00D, 32'h00000000};
    vecs[6] = '{1'b1, 1'b1, 5'd30, 32'h00000001, 5'd31, 5'd30, 32'hCAFEF00D, 32'hCAFEF00D, 32'h00000001};
    vecs[7] = '{1'b1, 1'b1, 5'd1,  32'h12345678, 5'd2,  5'd1,  32'h00000000, 32'h00000000, 32'h12345678};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 5'd1,  5'd30, 32'h12345678, 32'h00000000, 32'h12345678};
    vecs[9] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 5'd1,  5'd30, 32'h12345678, 32'h12345678, 32'h00000001};

    reset          = 1'b1;
    enable         = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    rd_addr        = '0;
    dif.dump_start = 1'b0;
    dif.dump_ready = 1'b0;
    model_clear();
    step();
    step();
    reset = 1'b0;

    checkOutput("reset_rd0", rd_data[31:0], 32'd0);
    checkOutput("reset_rd1", rd_data[63:32], 32'd0);
    checkOutput("reset_comb", rd_data0_comb, 32'd0);
    checkOutput("reset_valid", 32'(dif.dump_valid), 32'd0);
    checkOutput("reset_busy", 32'(dif.dump_busy), 32'd0);
    checkOutput("reset_done", 32'(dif.dump_done), 32'd0);
    checkOutput("reset_idx", 32'(dif.dump_idx), 32'd0);
    checkOutput("reset_data", dif.dump_data, 32'd0);

    run_dump(1'b0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_comb_before_edge", i), rd_data0_comb, vecs[i].exp_comb);
      if (vecs[i].en && vecs[i].we) model_write(vecs[i].wa, vecs[i].wd);
      r.d0 = vecs[i].exp0;
      r.d1 = vecs[i].exp1;
      rd_q.push_back(r);
      step();
      r = rd_q.pop_front();
      checkOutput($sformatf("vec%0d_rd0", i), rd_data[31:0], r.d0);
      checkOutput($sformatf("vec%0d_rd1", i), rd_data[63:32], r.d1);
      checkOutput($sformatf("vec%0d_comb_after_edge", i), rd_data0_comb, model_read(vecs[i].ra0));
    end
    enable = 1'b0;
    wr_en  = 1'b0;

    run_dump(1'b0);
    run_dump(1'b1);

    // Stall with ready 1,0,0,1 while overwriting the register held in the stalled beat.
    dif.dump_start = 1'b1;
    dif.dump_ready = 1'b1;
    step();
    dif.dump_start = 1'b0;
    checkOutput("stall_idx0", 32'(dif.dump_idx), 32'd0);
    step();
    checkOutput("stall_idx1", 32'(dif.dump_idx), 32'd1);
    checkOutput("stall_data1", dif.dump_data, model_read(5'd1));
    held           = model_read(5'd1);
    dif.dump_ready = 1'b0;
    enable         = 1'b1;
    wr_en          = 1'b1;
    wr_addr        = dif.dump_idx;
    wr_data        = 32'hAAAA5555;
    model_write(5'd1, 32'hAAAA5555);
    step();
    enable = 1'b0;
    wr_en  = 1'b0;
    checkOutput("stall_hold_idx_a", 32'(dif.dump_idx), 32'd1);
    checkOutput("stall_hold_data_a", dif.dump_data, held);
    step();
    checkOutput("stall_hold_idx_b", 32'(dif.dump_idx), 32'd1);
    checkOutput("stall_hold_data_b", dif.dump_data, held);
    checkOutput("stall_hold_valid", 32'(dif.dump_valid), 32'd1);
    dif.dump_ready = 1'b1;
    step();
    checkOutput("stall_resume_idx2", 32'(dif.dump_idx), 32'd2);
    cycles = 0;
    while (!dif.dump_done && cycles < 2*DEPTH) begin
      step();
      cycles++;
    end
    checkOutput("stall_dump_done", 32'(dif.dump_done), 32'd1);
    dif.dump_ready = 1'b0;
    step();

    run_dump(1'b0);

    // Register 0 write with a same-edge read of address 0.
    enable  = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    rd_addr = {5'd0, 5'd0};
    model_write(5'd0, 32'hFFFFFFFF);
    step();
    enable = 1'b0;
    wr_en  = 1'b0;
    checkOutput("zero_reg_rd0", rd_data[31:0], model_read(5'd0));
    checkOutput("zero_reg_rd1", rd_data[63:32], model_read(5'd0));
    checkOutput("zero_reg_comb", rd_data0_comb, model_read(5'd0));

    run_dump(1'b0);

    // Reset in the middle of a dump.
    dif.dump_start = 1'b1;
    dif.dump_ready = 1'b1;
    step();
    dif.dump_start = 1'b0;
    cycles = 0;
    while (dif.dump_idx != 5'd10 && cycles < 2*DEPTH) begin
      step();
      cycles++;
    end
    checkOutput("mid_reset_reach_idx10", 32'(dif.dump_idx), 32'd10);
    reset = 1'b1;
    step();
    reset          = 1'b0;
    dif.dump_ready = 1'b0;
    model_clear();
    checkOutput("mid_reset_valid", 32'(dif.dump_valid), 32'd0);
    checkOutput("mid_reset_busy", 32'(dif.dump_busy), 32'd0);
    checkOutput("mid_reset_idx", 32'(dif.dump_idx), 32'd0);
    checkOutput("mid_reset_done", 32'(dif.dump_done), 32'd0);
    checkOutput("mid_reset_rd0", rd_data[31:0], 32'd0);
    step();
    checkOutput("mid_reset_no_done", 32'(dif.dump_done), 32'd0);

    run_dump(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp_dump.md
Name: regfile_mp_dump

Overview:
- Parametrised MIPS general-purpose register file with NUM_RD registered read ports and one write port.
- Same-cycle write-to-read bypass.
- Built-in dump engine streams every register out over a valid/ready handshake to the debug/UART unit.
- Sits in the ID stage. Its step enable is driven by the debug unit's pipeline-step control.

Parameters:
- WIDTH, 32, register width in bits
- DEPTH, 32, number of registers
- NB, $clog2(DEPTH), address width
- NUM_RD, 2, number of registered read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  pipeline step enable; gates register writes and read-port updates
- wr_en  in  1  write request
- wr_addr  in  NB  write address
- wr_data  in  WIDTH  write data
- rd_addr  in  NUM_RD*NB  packed read addresses; port i = [i*NB +: NB]
- rd_data  out  NUM_RD*WIDTH  registered read data; port i = [i*WIDTH +: WIDTH]
- rd_data0_comb  out  WIDTH  combinational read of port 0 address, no bypass (branch compare)
- dump_start  in  1  request full register dump
- dump_ready  in  1  consumer accepts current beat
- dump_valid  out  1  dump beat valid
- dump_data  out  WIDTH  dump beat data
- dump_idx  out  NB  register index of current beat
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset: all DEPTH registers cleared to 0. rd_data=0, dump_valid=0, dump_data=0, dump_idx=0, dump_busy=0, dump_done=0. FSM goes to IDLE. Reset overrides any dump in progress.
- Write:
  - Occurs when a rising edge sees enable=1 and wr_en=1; mem[wr_addr] <= wr_data.
  - wr_addr >= DEPTH (non-power-of-2 DEPTH) is ignored.
  - enable=0 blocks the write regardless of wr_en.
- Read ports:
  - Update on a rising edge with enable=1. Latency 1 cycle.
  - rd_data[i] <= (wr_en && wr_addr==rd_addr[i] && write permitted) ? wr_data : mem[rd_addr[i]]. This is the bypass: new data is visible in the same edge.
  - enable=0 holds rd_data.
  - Multiple ports reading the same address all get identical data.
- rd_data0_comb = mem[rd_addr[0]]. Reflects the write only after the edge.
- Dump FSM states IDLE, SEND, DONE:
  - IDLE: dump_start=1 -> SEND. dump_idx=0, dump_data<=mem[0] (bypassed), dump_valid=1, dump_busy=1.
  - SEND, dump_valid && dump_ready, dump_idx<DEPTH-1: dump_idx++. dump_data<=mem[dump_idx+1] (bypassed). dump_valid stays 1.
  - SEND, dump_valid && dump_ready, dump_idx==DEPTH-1: -> DONE. dump_valid=0.
  - SEND, dump_ready=0: dump_data and dump_idx held stable even if a write hits that register. The beat is a snapshot.
  - DONE: dump_done=1 for exactly one cycle -> IDLE. dump_busy=0 on entering IDLE.
  - dump_start is ignored while dump_busy=1 or in DONE.
  - Dump runs independently of enable. Writes during a dump are legal; already-sent beats are not revisited.
- Throughput: one beat per cycle with dump_ready held high. A full dump takes DEPTH cycles + 1 DONE cycle.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - Writes to address 0 are discarded.
  - The bypass never forwards to address 0.
  - Reads and dumps of index 0 return 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then dump with dump_ready=1 -> DEPTH beats, dump_idx 0..31, all data 0. dump_done pulses one cycle after the beat with idx 31.
- enable=1, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr port0=5, port1=5 same edge -> next cycle both rd_data ports = 0xDEADBEEF (bypass). rd_data0_comb = 0xDEADBEEF only after the edge.
- enable=0 with wr_en=1, wr_addr=7, wr_data=0x1234 -> mem[7] unchanged and rd_data held. Raising enable and reading 7 returns prior value.
- Dump with dump_ready toggled 1,0,0,1; write 0xAAAA5555 to the register currently at dump_idx while stalled -> dump_data stable through the stall. A later dump shows 0xAAAA5555.
- Reset asserted mid-dump at idx 10 -> next cycle dump_valid=0, dump_busy=0, dump_idx=0, no dump_done. A new dump_start restarts from idx 0.
- With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to addr 0 while reading addr 0 -> rd_data=0, dump beat 0 =0. Without the macro: 0xFFFFFFFF.
